// File: rtl/i2c_master_engine.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK/NACK, STOP.
// Every bit occupies one slot of four quarters, and each quarter lasts CLK_DIV clk cycles.
module i2c_master_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RNACK, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       q_q, q_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic             nack_q, nack_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             scl_q, scl_d;
    logic             oe_q, oe_d;
    logic             ready_q, ready_d;

    logic quarter_end, slot_end, sample;

    assign quarter_end = (div_q == DIV_LAST);
    assign slot_end    = quarter_end && (q_q == 2'd3);
    assign sample      = quarter_end && (q_q == 2'd2);

    // Outputs are derived from the next state so the pins change on the same edge as the slot.
    function automatic logic scl_of(state_t s, logic [1:0] q);
        case (s)
            S_IDLE, S_START: scl_of = 1'b1;
            default:         scl_of = q[1];
        endcase
    endfunction

    function automatic logic oe_of(state_t s, logic [1:0] q, logic msb);
        case (s)
            S_START:         oe_of = q[1];
            S_ADDR, S_WDATA: oe_of = ~msb;
            S_STOP:          oe_of = (q != 2'd3);
            default:         oe_of = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        q_d         = q_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = quarter_end ? '0 : div_q + 1'b1;
            if (quarter_end) begin
                q_d = q_q + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                q_d   = 2'd0;
                if (cmd_valid) begin
                    state_d = S_START;
                    shift_d = {cmd_addr, cmd_rw};
                    wdata_d = cmd_wdata;
                    rw_d    = cmd_rw;
                    nack_d  = 1'b0;
                    rdata_d = 8'h00;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd0;
                end
            end
            S_ADDR: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_AACK;
                        shift_d = wdata_q;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            S_AACK: begin
                if (sample) begin
                    nack_d = sda_i;
                end
                if (slot_end) begin
                    bit_d = 3'd0;
                    if (nack_q) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = rw_q ? S_RDATA : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_WACK;
                    end
                end
            end
            S_WACK: begin
                if (sample) begin
                    nack_d = sda_i;
                end
                if (slot_end) begin
                    state_d = S_STOP;
                end
            end
            S_RDATA: begin
                if (sample) begin
                    rdata_d = {rdata_q[6:0], sda_i};
                end
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_RNACK;
                    end
                end
            end
            S_RNACK: begin
                if (slot_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        scl_d   = scl_of(state_d, q_d);
        oe_d    = oe_of(state_d, q_d, shift_d[7]);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            q_q         <= 2'd0;
            nack_q      <= 1'b0;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            scl_q       <= 1'b1;
            oe_q        <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            q_q         <= q_d;
            nack_q      <= nack_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            scl_q       <= scl_d;
            oe_q        <= oe_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        bit_q   <= bit_d;
        shift_q <= shift_d;
        wdata_q <= wdata_d;
        rw_q    <= rw_d;
    end

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign scl_o     = scl_q;
    assign sda_oe    = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_nack  = nack_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine with a reactive open-drain target model.
module tb_i2c_master_engine;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, scl_o, sda_oe, sda_i, rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_rdata;

    always #5 clk = ~clk;

    // Target side of the wired-AND bus.
    logic       tdrive = 1'b1;
    logic       t_read = 1'b0;
    logic       t_ack_addr = 1'b1;
    logic       t_ack_data = 1'b1;
    logic [7:0] t_rd_byte = 8'h00;
    assign sda_i = ~sda_oe & tdrive;

    int errors = 0;
    int checks = 0;

    i2c_master_engine #(.CLK_DIV(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .scl_o     (scl_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    logic prev_scl = 1'b1;
    logic prev_oe  = 1'b0;
    int   fall = 0;
    int   rise = 0;
    int   hi_edges = 0;
    logic rbit [0:31];

    // Bus watcher: SDA edges while SCL is high, captured bits at SCL rise, target drive at SCL fall.
    always @(negedge clk) begin
        if (sda_oe !== prev_oe && scl_o === 1'b1) begin
            hi_edges++;
            if (sda_oe === 1'b1) begin
                fall = 0;
                rise = 0;
                tdrive = 1'b1;
                for (int i = 0; i < 32; i++) rbit[i] = 1'bx;
            end
        end
        if (prev_scl === 1'b0 && scl_o === 1'b1) begin
            rise++;
            if (rise < 32) rbit[rise] = sda_i;
        end
        if (prev_scl === 1'b1 && scl_o === 1'b0) begin
            fall++;
            if (fall == 9)
                tdrive = !t_ack_addr;
            else if (fall >= 10 && fall <= 17 && t_read && t_ack_addr)
                tdrive = t_rd_byte[17 - fall];
            else if (fall == 18 && !t_read)
                tdrive = !t_ack_data;
            else
                tdrive = 1'b1;
        end
        prev_scl = scl_o;
        prev_oe  = sda_oe;
    end

    function automatic logic [7:0] byte_at(input int first);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], rbit[first + i]};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] d, input logic hold);
        @(negedge clk);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = d;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int hb;
        int pulses;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl_o), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_nack", 32'(rsp_nack), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // T1: write 0x2A / 0xA5, both ACKed
        t_read = 1'b0; t_ack_addr = 1'b1; t_ack_data = 1'b1;
        hb = hi_edges;
        issue(7'h2A, 1'b0, 8'hA5, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_rsp(lat);
        chk("t1_latency", 32'(lat), 32'd320);
        chk("t1_nack", 32'(rsp_nack), 32'd0);
        chk("t1_rdata", 32'(rsp_rdata), 32'd0);
        chk("t1_addr_byte", 32'(byte_at(1)), 32'h54);
        chk("t1_aack_bit", 32'(rbit[9]), 32'd0);
        chk("t1_data_byte", 32'(byte_at(10)), 32'hA5);
        chk("t1_wack_bit", 32'(rbit[18]), 32'd0);
        chk("t1_scl_rises", 32'(rise), 32'd19);
        chk("t1_sda_hi_edges", 32'(hi_edges - hb), 32'd2);
        @(posedge clk);
        #1;
        chk("t1_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // T2: read 0x2A, target returns 0x3C
        t_read = 1'b1; t_rd_byte = 8'h3C;
        hb = hi_edges;
        issue(7'h2A, 1'b1, 8'hFF, 1'b0);
        wait_rsp(lat);
        chk("t2_latency", 32'(lat), 32'd320);
        chk("t2_addr_byte", 32'(byte_at(1)), 32'h55);
        chk("t2_aack_bit", 32'(rbit[9]), 32'd0);
        chk("t2_rdata", 32'(rsp_rdata), 32'h3C);
        chk("t2_nack", 32'(rsp_nack), 32'd0);
        chk("t2_master_nack_bit", 32'(rbit[18]), 32'd1);
        chk("t2_sda_hi_edges", 32'(hi_edges - hb), 32'd2);

        // T3: write 0x11, address NACKed
        t_read = 1'b0; t_ack_addr = 1'b0;
        hb = hi_edges;
        issue(7'h11, 1'b0, 8'h77, 1'b0);
        wait_rsp(lat);
        chk("t3_latency", 32'(lat), 32'd176);
        chk("t3_nack", 32'(rsp_nack), 32'd1);
        chk("t3_rdata", 32'(rsp_rdata), 32'd0);
        chk("t3_addr_byte", 32'(byte_at(1)), 32'h22);
        chk("t3_aack_bit", 32'(rbit[9]), 32'd1);
        chk("t3_scl_rises", 32'(rise), 32'd10);
        chk("t3_sda_hi_edges", 32'(hi_edges - hb), 32'd2);

        // T4: reset during address bit 3
        t_ack_addr = 1'b1;
        issue(7'h2A, 1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fall == 4) break;
        end
        chk("t4_reached_bit3", 32'(fall), 32'd4);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_scl", 32'(scl_o), 32'd1);
        chk("t4_sda_oe", 32'(sda_oe), 32'd0);
        chk("t4_ready", 32'(cmd_ready), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("t4_no_rsp", 32'(pulses), 32'd0);

        // T5: cmd_valid held, command changed mid-frame, back-to-back accept
        t_read = 1'b0; t_ack_addr = 1'b1; t_ack_data = 1'b1;
        hb = hi_edges;
        issue(7'h2A, 1'b0, 8'hA5, 1'b1);
        @(negedge clk);
        cmd_addr = 7'h33; cmd_rw = 1'b1; cmd_wdata = 8'h0F;
        wait_rsp(lat);
        chk("t5a_latency", 32'(lat), 32'd320);
        chk("t5a_addr_byte", 32'(byte_at(1)), 32'h54);
        chk("t5a_data_byte", 32'(byte_at(10)), 32'hA5);
        chk("t5a_nack", 32'(rsp_nack), 32'd0);
        chk("t5a_ready_in_rsp", 32'(cmd_ready), 32'd1);
        chk("t5a_sda_hi_edges", 32'(hi_edges - hb), 32'd2);
        t_read = 1'b1; t_rd_byte = 8'h96;
        hb = hi_edges;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("t5b_accepted", 32'(busy), 32'd1);
        wait_rsp(lat);
        chk("t5b_latency", 32'(lat), 32'd320);
        chk("t5b_addr_byte", 32'(byte_at(1)), 32'h67);
        chk("t5b_rdata", 32'(rsp_rdata), 32'h96);
        chk("t5b_nack", 32'(rsp_nack), 32'd0);
        chk("t5b_sda_hi_edges", 32'(hi_edges - hb), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
